ctr_block_gen: RTL and testbench
================================

// Module: ctr_block_gen
// PURPOSE
//   Upstream CTR-mode counter-block generator for the encryption core. Forms each input
//   block as {nonce, counter} and presents it on block_out. Strobes block_next once per
//   block, then waits for the core's ready pulse before advancing the counter. Stops after
//   a programmed block count, and never issues a repeated counter value.
// PARAMETERS
//   BLK_W   128  cipher block width
//   CTR_W   64   counter field width, occupying block_out[CTR_W-1:0]
//   CNT_W   32   width of num_blocks / blocks_issued
// PORTS
//   clk            in   1              single clock, rising edge
//   reset          in   1              asynchronous, active-low reset
//   load           in   1              start request; sampled only in IDLE
//   abort          in   1              synchronous cancel; returns to IDLE, no done pulse
//   nonce          in   BLK_W-CTR_W    fixed upper field, captured on load
//   init_ctr       in   CTR_W          first counter value, captured on load
//   num_blocks     in   CNT_W          blocks to issue, captured on load
//   key_ready      in   1              key schedule complete (level)
//   enc_ready      in   1              core finished current block (1-cycle pulse)
//   block_out      out  BLK_W          {nonce_q, ctr_q} to core block input
//   block_next     out  1              1-cycle start strobe to core
//   busy           out  1              high in every state except IDLE
//   done           out  1              1-cycle pulse on run completion
//   wrap_err       out  1              sticky; counter would wrap; cleared by next accepted load
//   blocks_issued  out  CNT_W          blocks completed in the current run
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; nonce_q, ctr_q and num_q are 0.
//   - FSM: IDLE, WAIT_KEY, ISSUE, WAIT_ENC, DONE. State and outputs are registered.
//   - IDLE: on load, capture nonce, init_ctr and num_blocks; clear blocks_issued and wrap_err.
//     If num_blocks==0, go to DONE; otherwise go to WAIT_KEY. load in any other state is ignored.
//   - WAIT_KEY: go to ISSUE in the cycle after key_ready is seen high.
//   - ISSUE: block_next=1 for exactly this cycle. block_out is already stable. Go to WAIT_ENC.
//   - WAIT_ENC: block_out is held and block_next=0. On enc_ready:
//     * blocks_issued is incremented.
//     * If blocks_issued+1==num_q, go to DONE.
//     * Otherwise, if ctr_q is all-ones, set wrap_err and go to DONE. ctr_q is not incremented.
//     * Otherwise, ctr_q+1 (mod 2^CTR_W, nonce field untouched) and go to ISSUE.
//   - Run completion takes priority over wrap: when the last requested block uses the
//     all-ones counter, the run ends normally with no error.
//   - enc_ready outside WAIT_ENC is ignored.
//   - Minimum spacing between block_next pulses is 2 cycles (ISSUE, WAIT_ENC+ready).
//   - DONE: done=1 for one cycle, then IDLE. busy is still 1 in DONE and drops in IDLE.
//   - abort: from any state, IDLE next cycle. It wins over load, enc_ready and key_ready in
//     the same cycle. block_next, done and busy are 0 next cycle; blocks_issued and wrap_err
//     keep their values.
//   - Asserting reset mid-run clears everything immediately. The core is reset by the same
//     net, so no handshake is left pending.
//   - Latency from load (num>0, key_ready already high): block_next is high 2 cycles later.
// STRUCTURE
//   - Shared package aes_ctr_pkg: BLK_W/CTR_W defaults and the state enum
//     (IDLE=0, WAIT_KEY=1, ISSUE=2, WAIT_ENC=3, DONE=4; 3-bit encoding).
//   - One natural sub-module, ctr_incr: a CTR_W-bit register with load, inc and
//     an all_ones flag. All remaining logic is a single FSM in this module.
// TESTING
//   1. nonce=64'hA5A5_0000_0000_0001, init_ctr=0, num=3, key_ready=1, core returns
//      enc_ready 4 cycles after each block_next. Expect three block_next pulses with
//      block_out[63:0]=0,1,2 and upper half constant. Then done pulses once,
//      blocks_issued=3, wrap_err=0.
//   2. num_blocks=0 -> no block_next; done pulses 1 cycle after load; busy high exactly 1 cycle.
//   3. init_ctr=64'hFFFF_FFFF_FFFF_FFFE, num=5 -> blocks with ctr ..FE and ..FF are issued,
//      then wrap_err=1, done pulses, blocks_issued=2. The next accepted load clears wrap_err.
//   4. key_ready held low 10 cycles after load -> busy=1 with no block_next. First block_next
//      comes 2 cycles after key_ready rises.
//   5. abort in WAIT_ENC during block 2 of 4 -> IDLE next cycle, no done. Late enc_ready
//      is ignored, blocks_issued=1. A new load starts cleanly from its own init_ctr.
//   6. Drive reset low mid-ISSUE -> all outputs 0 asynchronously. load while busy and
//      stray enc_ready in IDLE must not change state.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the CTR-mode front end: default field widths and FSM state encoding.
package aes_ctr_pkg;

   localparam int DEF_BLK_W = 128;
   localparam int DEF_CTR_W = 64;
   localparam int DEF_CNT_W = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_KEY = 3'd1,
      ISSUE    = 3'd2,
      WAIT_ENC = 3'd3,
      DONE     = 3'd4
   } state_e;

endpackage

// File: rtl/ctr_block_gen_ctr_incr.sv
// Counter field register: load has priority over increment; all_ones flags the wrap point.
module ctr_incr
   import aes_ctr_pkg::*;
#(
   parameter int CTR_W = DEF_CTR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CTR_W-1:0] load_val,
   input  logic             inc,
   output logic [CTR_W-1:0] ctr,
   output logic             all_ones
);

   logic [CTR_W-1:0] ctr_q, ctr_d;

   always_comb begin
      ctr_d = ctr_q;
      if (load)     ctr_d = load_val;
      else if (inc) ctr_d = ctr_q + CTR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ctr_q <= '0;
      else        ctr_q <= ctr_d;
   end

   assign ctr      = ctr_q;
   assign all_ones = &ctr_q;

endmodule

// File: rtl/ctr_block_gen.sv
// CTR-mode counter-block generator: issues {nonce, counter} blocks to the cipher core,
// one per enc_ready handshake, stopping on the programmed count or before a counter wrap.
module ctr_block_gen
   import aes_ctr_pkg::*;
#(
   parameter int BLK_W = DEF_BLK_W,
   parameter int CTR_W = DEF_CTR_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   abort,
   input  logic [BLK_W-CTR_W-1:0] nonce,
   input  logic [CTR_W-1:0]       init_ctr,
   input  logic [CNT_W-1:0]       num_blocks,
   input  logic                   key_ready,
   input  logic                   enc_ready,
   output logic [BLK_W-1:0]       block_out,
   output logic                   block_next,
   output logic                   busy,
   output logic                   done,
   output logic                   wrap_err,
   output logic [CNT_W-1:0]       blocks_issued
);

   localparam int NON_W = BLK_W - CTR_W;

   state_e           state_q, state_d;
   logic [NON_W-1:0] nonce_q, nonce_d;
   logic [CNT_W-1:0] num_q, num_d, issued_q, issued_d, issued_inc;
   logic             block_next_q, block_next_d;
   logic             done_q, done_d, busy_q, busy_d, wrap_q, wrap_d;
   logic             key_ready_q, key_ready_d;
   logic             ctr_load, ctr_inc, ctr_all_ones;
   logic [CTR_W-1:0] ctr;

   ctr_incr #(.CTR_W(CTR_W)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (init_ctr),
      .inc      (ctr_inc),
      .ctr      (ctr),
      .all_ones (ctr_all_ones)
   );

   assign issued_inc = issued_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      nonce_d      = nonce_q;
      num_d        = num_q;
      issued_d     = issued_q;
      busy_d       = busy_q;
      wrap_d       = wrap_q;
      block_next_d = 1'b0;
      done_d       = 1'b0;
      ctr_load     = 1'b0;
      ctr_inc      = 1'b0;
      // key_ready is registered so the issue decision never sits on the core's timing path
      key_ready_d  = key_ready;
      if (abort) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (load) begin
               nonce_d  = nonce;
               num_d    = num_blocks;
               issued_d = '0;
               wrap_d   = 1'b0;
               ctr_load = 1'b1;
               busy_d   = 1'b1;
               if (num_blocks == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = WAIT_KEY;
               end
            end
            WAIT_KEY: if (key_ready_q) begin
               state_d      = ISSUE;
               block_next_d = 1'b1;
            end
            ISSUE: state_d = WAIT_ENC;
            WAIT_ENC: if (enc_ready) begin
               issued_d = issued_inc;
               // reaching the requested count wins over the wrap check
               if (issued_inc == num_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (ctr_all_ones) begin
                  wrap_d  = 1'b1;
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  ctr_inc      = 1'b1;
                  state_d      = ISSUE;
                  block_next_d = 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         nonce_q      <= '0;
         num_q        <= '0;
         issued_q     <= '0;
         block_next_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         wrap_q       <= 1'b0;
         key_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         nonce_q      <= nonce_d;
         num_q        <= num_d;
         issued_q     <= issued_d;
         block_next_q <= block_next_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         wrap_q       <= wrap_d;
         key_ready_q  <= key_ready_d;
      end
   end

   assign block_out     = {nonce_q, ctr};
   assign block_next    = block_next_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign wrap_err      = wrap_q;
   assign blocks_issued = issued_q;

endmodule

// File: tb/tb_ctr_block_gen.sv
// Scenario bench for ctr_block_gen: expected blocks are queued at load and popped on block_next.
module tb_ctr_block_gen;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0, abort = 1'b0, key_ready = 1'b0, enc_ready = 1'b0;
   logic [63:0]   nonce = '0;
   logic [63:0]   init_ctr = '0;
   logic [31:0]   num_blocks = '0;
   logic [127:0]  block_out;
   logic          block_next, busy, done, wrap_err;
   logic [31:0]   blocks_issued;

   int            n_cmp = 0;
   int            n_err = 0;
   int            bn_cnt = 0;
   int            done_cnt = 0;
   logic [127:0]  exp_q[$];
   logic [127:0]  exp_blk;

   ctr_block_gen dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .abort         (abort),
      .nonce         (nonce),
      .init_ctr      (init_ctr),
      .num_blocks    (num_blocks),
      .key_ready     (key_ready),
      .enc_ready     (enc_ready),
      .block_out     (block_out),
      .block_next    (block_next),
      .busy          (busy),
      .done          (done),
      .wrap_err      (wrap_err),
      .blocks_issued (blocks_issued)
   );

   always #5 clk = ~clk;

   // scoreboard: every strobe must match the next queued block
   always @(negedge clk) begin
      if (reset === 1'b1 && block_next === 1'b1) begin
         bn_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra: block_out=%h issued, required no block", block_out);
         end else begin
            exp_blk = exp_q.pop_front();
            if (block_out !== exp_blk) begin
               n_err++;
               $display("FAIL sb_block: block_out=%h required %h", block_out, exp_blk);
            end
         end
      end
      if (reset === 1'b1 && done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [63:0] n, input logic [63:0] c, input logic [31:0] num);
      nonce = n; init_ctr = c; num_blocks = num; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // core model: answer each strobe with enc_ready lat cycles later
   task automatic serve(input int n, input int lat);
      for (int b = 0; b < n; b++) begin
         int t = 0;
         while (block_next !== 1'b1 && t < 100) begin tick(); t++; end
         if (block_next !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL serve_wait: block %0d block_next=%b required 1 within 100 cycles", b, block_next);
            return;
         end
         repeat (lat) tick();
         enc_ready = 1'b1;
         tick();
         enc_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      tick(); tick();
      n_cmp++; if (block_out !== '0) begin n_err++; $display("FAIL rst_block_out: got %h required 0", block_out); end
      n_cmp++; if ({block_next, busy, done, wrap_err} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b required 0000", {block_next, busy, done, wrap_err}); end
      n_cmp++; if (blocks_issued !== '0) begin n_err++; $display("FAIL rst_issued: got %0d required 0", blocks_issued); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [63:0] n = 64'hA5A5_0000_0000_0001;
      int d0 = done_cnt;
      key_ready = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) exp_q.push_back({n, 64'(k)});
      start(n, 64'd0, 32'd3);
      n_cmp++; if (block_next !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_wait: bn=%b busy=%b required 0/1", block_next, busy); end
      tick();
      n_cmp++; if (block_next !== 1'b1) begin n_err++; $display("FAIL basic_latency: bn=%b required 1", block_next); end
      serve(3, 4);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b required 1", done); end
      n_cmp++; if (blocks_issued !== 32'd3) begin n_err++; $display("FAIL basic_issued: got %0d required 3", blocks_issued); end
      n_cmp++; if (wrap_err !== 1'b0) begin n_err++; $display("FAIL basic_wrap: got %b required 0", wrap_err); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: done=%b busy=%b required 0/0", done, busy); end
      n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt - d0); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_sb_left: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_zero();
      int b0 = bn_cnt;
      start(64'h1234, 64'd9, 32'd0);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL zero_done: done=%b busy=%b required 1/1", done, busy); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_idle: done=%b busy=%b required 0/0", done, busy); end
      repeat (3) tick();
      n_cmp++; if (bn_cnt != b0) begin n_err++; $display("FAIL zero_no_block: got %0d strobes required 0", bn_cnt - b0); end
   endtask

   task automatic test_wrap();
      logic [63:0] n = 64'h0123_4567_89AB_CDEF;
      key_ready = 1'b1;
      exp_q.push_back({n, 64'hFFFF_FFFF_FFFF_FFFE});
      exp_q.push_back({n, 64'hFFFF_FFFF_FFFF_FFFF});
      start(n, 64'hFFFF_FFFF_FFFF_FFFE, 32'd5);
      serve(2, 1);
      n_cmp++; if (done !== 1'b1 || wrap_err !== 1'b1) begin n_err++; $display("FAIL wrap_done: done=%b wrap=%b required 1/1", done, wrap_err); end
      n_cmp++; if (blocks_issued !== 32'd2) begin n_err++; $display("FAIL wrap_issued: got %0d required 2", blocks_issued); end
      tick(); tick();
      n_cmp++; if (wrap_err !== 1'b1) begin n_err++; $display("FAIL wrap_sticky: got %b required 1", wrap_err); end
      // last requested block on the all-ones counter ends normally
      exp_q.push_back({n, 64'hFFFF_FFFF_FFFF_FFFF});
      start(n, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1);
      n_cmp++; if (wrap_err !== 1'b0) begin n_err++; $display("FAIL wrap_clear: got %b required 0", wrap_err); end
      serve(1, 2);
      n_cmp++; if (done !== 1'b1 || wrap_err !== 1'b0 || blocks_issued !== 32'd1) begin n_err++; $display("FAIL wrap_priority: done=%b wrap=%b issued=%0d required 1/0/1", done, wrap_err, blocks_issued); end
      tick();
   endtask

   task automatic test_key_wait();
      logic [63:0] n = 64'hBEEF;
      int bad = 0;
      key_ready = 1'b0;
      tick();
      exp_q.push_back({n, 64'd40});
      start(n, 64'd40, 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (busy !== 1'b1 || block_next !== 1'b0) bad++;
         tick();
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL key_hold: %0d bad cycles required 0", bad); end
      key_ready = 1'b1;
      tick();
      n_cmp++; if (block_next !== 1'b0) begin n_err++; $display("FAIL key_early: bn=%b required 0", block_next); end
      tick();
      n_cmp++; if (block_next !== 1'b1) begin n_err++; $display("FAIL key_latency: bn=%b required 1", block_next); end
      serve(1, 3);
      n_cmp++; if (done !== 1'b1 || blocks_issued !== 32'd1) begin n_err++; $display("FAIL key_done: done=%b issued=%0d required 1/1", done, blocks_issued); end
      tick();
   endtask

   task automatic test_abort();
      logic [63:0] n = 64'hCAFE;
      int d0;
      key_ready = 1'b1;
      d0 = done_cnt;
      exp_q.push_back({n, 64'd100});
      exp_q.push_back({n, 64'd101});
      start(n, 64'd100, 32'd4);
      serve(1, 3);
      n_cmp++; if (block_next !== 1'b1) begin n_err++; $display("FAIL abort_blk2: bn=%b required 1", block_next); end
      tick();
      abort = 1'b1; enc_ready = 1'b1; load = 1'b1;
      tick();
      abort = 1'b0; enc_ready = 1'b0; load = 1'b0;
      n_cmp++; if ({busy, block_next, done} !== 3'b000) begin n_err++; $display("FAIL abort_idle: busy/bn/done=%b required 000", {busy, block_next, done}); end
      n_cmp++; if (blocks_issued !== 32'd1) begin n_err++; $display("FAIL abort_issued: got %0d required 1", blocks_issued); end
      enc_ready = 1'b1;
      tick();
      enc_ready = 1'b0;
      tick();
      n_cmp++; if (blocks_issued !== 32'd1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_late: issued=%0d busy=%b required 1/0", blocks_issued, busy); end
      n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0); end
      exp_q.push_back({n, 64'd500});
      exp_q.push_back({n, 64'd501});
      start(n, 64'd500, 32'd2);
      serve(2, 2);
      n_cmp++; if (done !== 1'b1 || blocks_issued !== 32'd2) begin n_err++; $display("FAIL abort_restart: done=%b issued=%0d required 1/2", done, blocks_issued); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [63:0] n = 64'hD00D;
      key_ready = 1'b1;
      exp_q.push_back({n, 64'd7});
      start(n, 64'd7, 32'd3);
      tick();
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      n_cmp++; if ({block_next, busy, done, wrap_err} !== 4'b0 || block_out !== '0 || blocks_issued !== '0) begin n_err++; $display("FAIL midrst_clear: flags=%b out=%h issued=%0d required all 0", {block_next, busy, done, wrap_err}, block_out, blocks_issued); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      enc_ready = 1'b1;
      tick();
      enc_ready = 1'b0;
      n_cmp++; if (busy !== 1'b0 || blocks_issued !== '0 || block_next !== 1'b0) begin n_err++; $display("FAIL stray_enc: busy=%b issued=%0d bn=%b required 0/0/0", busy, blocks_issued, block_next); end
      exp_q.push_back({n, 64'd20});
      exp_q.push_back({n, 64'd21});
      start(n, 64'd20, 32'd2);
      tick();
      nonce = 64'h9999; init_ctr = 64'd900; num_blocks = 32'd1; load = 1'b1;
      tick(); tick();
      load = 1'b0;
      enc_ready = 1'b1;
      tick();
      enc_ready = 1'b0;
      serve(1, 3);
      n_cmp++; if (done !== 1'b1 || blocks_issued !== 32'd2) begin n_err++; $display("FAIL busy_load: done=%b issued=%0d required 1/2", done, blocks_issued); end
      tick();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_left: got %0d required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_wrap();
      test_key_wait();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
